// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, field
// positions of the pre-split instruction outputs and the sequential PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential PC+4, or PC+4 plus a sign-extended word offset.
// Purely combinational, modulo 2^ADDR_W.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              npc_sel,
    input  logic [15:0]       branch_imm,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_off;

    always_comb begin
        pc_plus4   = pc + ADDR_W'(PC_INC);
        branch_off = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};
        next_pc    = npc_sel ? (pc_plus4 + branch_off) : pc_plus4;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, imem req/ready fetch and valid/ready
// hand-off to decode. Define INSTR_FETCH_PERF_CNT_EN to add retired/stall counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        op_code,
    output logic [5:0]        funct,
`ifdef INSTR_FETCH_PERF_CNT_EN
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt,
`endif
    input  logic              npc_sel,
    input  logic [15:0]       branch_imm
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, next_pc;
    logic              capture, advance;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc         (pc),
        .npc_sel    (npc_sel),
        .branch_imm (branch_imm),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // req/valid decode straight from state so reset withdraws them at once
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    advance    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            instr    <= '0;
            instr_pc <= RESET_PC;
        end else begin
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (advance) pc <= next_pc;
        end
    end

    assign imem_addr = pc;
    assign op_code   = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

`ifdef INSTR_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (advance) retired_cnt <= retired_cnt + 32'd1;
            if ((state == FETCH && !imem_ready) || (state == HOLD && !instr_ready))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand sequences for branch,
// wrap and reset corners, then random traffic against a behavioural model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        npc_sel;
    logic [15:0] branch_imm;

    logic        d0_req, d1_req, d0_valid, d1_valid;
    logic [31:0] d0_addr, d1_addr, d0_instr, d1_instr, d0_ipc, d1_ipc;
    logic [5:0]  d0_op, d1_op, d0_fn, d1_fn;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] d0_ret, d0_stall, d1_ret, d1_stall;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .imem_req(d0_req), .imem_addr(d0_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(d0_valid),
        .instr_ready(instr_ready), .instr(d0_instr), .instr_pc(d0_ipc),
        .op_code(d0_op), .funct(d0_fn),
`ifdef INSTR_FETCH_PERF_CNT_EN
        .retired_cnt(d0_ret), .stall_cnt(d0_stall),
`endif
        .npc_sel(npc_sel), .branch_imm(branch_imm)
    );

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n), .imem_req(d1_req), .imem_addr(d1_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(d1_valid),
        .instr_ready(instr_ready), .instr(d1_instr), .instr_pc(d1_ipc),
        .op_code(d1_op), .funct(d1_fn),
`ifdef INSTR_FETCH_PERF_CNT_EN
        .retired_cnt(d1_ret), .stall_cnt(d1_stall),
`endif
        .npc_sel(npc_sel), .branch_imm(branch_imm)
    );

    // Behavioural model: per-instance PC, "instruction on offer" flag and counters
    logic [31:0] rpc [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
    logic [31:0] m_pc [2], m_instr [2], m_ipc [2], m_ret [2], m_stall [2];
    bit          m_started [2], m_hold [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int off;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pc[k] = rpc[k]; m_ipc[k] = rpc[k]; m_instr[k] = '0;
                m_started[k] = 0; m_hold[k] = 0; m_ret[k] = '0; m_stall[k] = '0;
            end else if (!m_started[k]) begin
                m_started[k] = 1;
            end else if (!m_hold[k]) begin
                if (imem_ready) begin
                    m_hold[k] = 1; m_instr[k] = imem_rdata; m_ipc[k] = m_pc[k];
                end else m_stall[k] = m_stall[k] + 1;
            end else begin
                if (instr_ready) begin
                    off = int'($signed(branch_imm));
                    m_pc[k] = m_pc[k] + 32'd4 + (npc_sel ? 32'(off * 4) : 32'd0);
                    m_hold[k] = 0; m_ret[k] = m_ret[k] + 1;
                end else m_stall[k] = m_stall[k] + 1;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] ins, input logic [31:0] ipc,
                             input logic [5:0] op, input logic [5:0] fn);
        logic [31:0] mi;
        mi = m_instr[k];
        chk($sformatf("m%0d_req", k),   {31'd0, req},   {31'd0, m_started[k] && !m_hold[k]});
        chk($sformatf("m%0d_addr", k),  addr,           m_pc[k]);
        chk($sformatf("m%0d_valid", k), {31'd0, valid}, {31'd0, m_hold[k]});
        chk($sformatf("m%0d_instr", k), ins,            mi);
        chk($sformatf("m%0d_ipc", k),   ipc,            m_ipc[k]);
        chk($sformatf("m%0d_op", k),    {26'd0, op},    {26'd0, mi[31:26]});
        chk($sformatf("m%0d_fn", k),    {26'd0, fn},    {26'd0, mi[5:0]});
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_dut(0, d0_req, d0_addr, d0_valid, d0_instr, d0_ipc, d0_op, d0_fn);
        check_dut(1, d1_req, d1_addr, d1_valid, d1_instr, d1_ipc, d1_op, d1_fn);
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("m0_ret", d0_ret, m_ret[0]);   chk("m0_stall", d0_stall, m_stall[0]);
        chk("m1_ret", d1_ret, m_ret[1]);   chk("m1_stall", d1_stall, m_stall[1]);
`endif
    endtask

    task automatic idle_inputs();
        imem_ready = 0; imem_rdata = '0; instr_ready = 0; npc_sel = 0; branch_imm = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; idle_inputs();
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic do_fetch(input logic [31:0] data);
        imem_ready = 1; imem_rdata = data; instr_ready = 0; tick(); imem_ready = 0;
    endtask

    task automatic do_retire(input logic sel, input logic [15:0] imm);
        instr_ready = 1; npc_sel = sel; branch_imm = imm; tick();
        instr_ready = 0; npc_sel = 0; branch_imm = '0;
    endtask

    typedef struct {
        logic        mr;  logic [31:0] rd; logic ir; logic ns; logic [15:0] bi;
        logic        e_req; logic [31:0] e_addr; logic e_valid;
        logic [31:0] e_instr; logic [31:0] e_ipc;
    } vec_t;

    vec_t vt [12];

    initial begin
        // inputs (mr rd ir ns bi) -> expected after the next edge (req addr valid instr ipc)
        vt[0]  = '{1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 16'h0010, 1'b1, 32'h0, 1'b0, 32'h0,         32'h0};
        vt[1]  = '{1'b1, 32'h8C01_0004, 1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b1, 32'h8C01_0004, 32'h0};
        vt[2]  = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'h0000, 1'b1, 32'h4, 1'b0, 32'h8C01_0004, 32'h0};
        vt[3]  = '{1'b1, 32'h1022_FFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h4, 1'b1, 32'h1022_FFFF, 32'h4};
        vt[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 16'h0000, 1'b1, 32'h8, 1'b0, 32'h1022_FFFF, 32'h4};
        vt[5]  = '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h8, 1'b1, 32'h0000_0020, 32'h8};
        for (int i = 6; i < 11; i++)
            vt[i] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 16'h0040, 1'b0, 32'h8, 1'b1, 32'h0000_0020, 32'h8};
        vt[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 16'h0000, 1'b1, 32'hC, 1'b0, 32'h0000_0020, 32'h8};

        // reset state and directed table
        do_reset();
        chk("idle_req", {31'd0, d0_req}, 32'd0);
        chk("idle_valid", {31'd0, d0_valid}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            imem_ready = vt[i].mr; imem_rdata = vt[i].rd; instr_ready = vt[i].ir;
            npc_sel = vt[i].ns; branch_imm = vt[i].bi;
            tick();
            chk($sformatf("v%0d_req", i),   {31'd0, d0_req},   {31'd0, vt[i].e_req});
            chk($sformatf("v%0d_addr", i),  d0_addr,           vt[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, d0_valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("v%0d_instr", i), d0_instr,          vt[i].e_instr);
            chk($sformatf("v%0d_ipc", i),   d0_ipc,            vt[i].e_ipc);
            chk($sformatf("v%0d_op", i),    {26'd0, d0_op},    {26'd0, vt[i].e_instr[31:26]});
            chk($sformatf("v%0d_fn", i),    {26'd0, d0_fn},    {26'd0, vt[i].e_instr[5:0]});
            if (i == 0) chk("wrap_first_addr", d1_addr, 32'hFFFF_FFFC);
            if (i == 2) chk("wrap_second_addr", d1_addr, 32'h0000_0000);
        end
        idle_inputs();

        // branches: reach 0x100, back to 0xFC, then forward to 0x110
        do_reset(); tick();
        do_fetch(32'h1000_003F); do_retire(1'b1, 16'h003F);
        chk("br_to_100", d0_addr, 32'h0000_0100);
        do_fetch(32'h1000_FFFE); do_retire(1'b1, 16'hFFFE);
        chk("br_back_fc", d0_addr, 32'h0000_00FC);
        do_fetch(32'h0000_0020); do_retire(1'b0, 16'hFFFE);
        chk("seq_to_100", d0_addr, 32'h0000_0100);
        do_fetch(32'h1000_0003); do_retire(1'b1, 16'h0003);
        chk("br_fwd_110", d0_addr, 32'h0000_0110);

        // negative branch below zero wraps
        do_reset(); tick();
        do_fetch(32'h1000_FFFE); do_retire(1'b1, 16'hFFFE);
        chk("br_neg_wrap", d0_addr, 32'hFFFF_FFFC);

        // memory stall then reset mid-fetch
        do_reset(); tick();
        do_fetch(32'h0); do_retire(1'b0, 16'h0);
        imem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req", {31'd0, d0_req}, 32'd1);
            chk("stall_addr", d0_addr, 32'h4);
        end
        #2 rst_n = 0;
        #1 chk("async_req_drop", {31'd0, d0_req}, 32'd0);
        tick(); rst_n = 1; tick();
        chk("restart_req", {31'd0, d0_req}, 32'd1);
        chk("restart_addr", d0_addr, 32'h0);

        // reset while holding an instruction
        do_fetch(32'h0123_4567);
        #2 rst_n = 0;
        #1 chk("async_valid_drop", {31'd0, d0_valid}, 32'd0);
        chk("async_instr_clr", d0_instr, 32'h0);
        tick(); rst_n = 1;

`ifdef INSTR_FETCH_PERF_CNT_EN
        do_reset(); tick();
        for (int n = 0; n < 3; n++) begin
            imem_ready = 0; tick(); tick();
            do_fetch(32'h0000_0020 + n); do_retire(1'b0, 16'h0);
        end
        chk("perf_retired", d0_ret, 32'd3);
        chk("perf_stall", d0_stall, 32'd6);
`endif

        // random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 249) != 0);
            imem_ready  = ($urandom_range(0, 2) != 0);
            imem_rdata  = $urandom;
            instr_ready = ($urandom_range(0, 2) != 0);
            npc_sel     = $urandom_range(0, 1);
            branch_imm  = 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage of the single-cycle MIPS datapath. It holds the PC and issues word fetches to instruction memory over a req/ready handshake. It presents the fetched instruction, with pre-split op_code and funct fields, to the control/decode stage over a valid/ready handshake. It consumes the control stage's nPC_Sel and the branch immediate to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word aligned.
ADDR_W, 32, PC and instruction-memory address width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  ADDR_W  fetch address, always equal to pc.
imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
imem_rdata  in  32  instruction word.
instr_valid  out  1  instr/op_code/funct/instr_pc are valid.
instr_ready  in  1  decode/control stage accepts the instruction.
instr  out  32  fetched instruction.
instr_pc  out  ADDR_W  address of instr.
op_code  out  6  instr[31:26].
funct  out  6  instr[5:0].
npc_sel  in  1  from control: 1 = take branch. Sampled only on the decode handshake.
branch_imm  in  16  branch offset in words. Sampled only on the decode handshake.

Behaviour:
- Reset is asynchronous and active-low; everything is clocked on the rising edge of one clock.
  - While rst_n is low, immediately: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr/op_code/funct=0, instr_pc=RESET_PC.
- State machine:
  - IDLE: one cycle after reset release, imem_req=0, then go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. imem_req stays high until imem_ready=1.
    - On the imem_ready cycle: latch imem_rdata into instr, instr[31:26] into op_code, instr[5:0] into funct, and pc into instr_pc; go to HOLD.
  - HOLD: instr_valid=1, imem_req=0. Outputs stay stable until instr_valid & instr_ready.
    - On the handshake cycle: pc <= next_pc, instr_valid <= 0, go to FETCH.
- Next-PC rule, 32-bit modulo arithmetic:
  - pc_plus4 = pc + 4.
  - next_pc = npc_sel ? pc_plus4 + (sign_extend(branch_imm) << 2) : pc_plus4.
  - Overflow wraps silently, e.g. 32'hFFFF_FFFC + 4 = 32'h0000_0000. A negative branch below 0 also wraps.
- Latency and throughput:
  - Minimum reset-release to first instr_valid is 3 cycles (IDLE, FETCH with imem_ready=1, HOLD visible).
  - Steady state is 1 instruction per 2 cycles.
- Boundary conditions:
  - instr_ready high outside HOLD is ignored.
  - npc_sel and branch_imm are ignored outside the HOLD handshake cycle.
  - imem_ready high while imem_req=0 is ignored; no data is latched.
  - imem_ready held low: stay in FETCH indefinitely with addr stable.
  - rst_n asserted mid-fetch or mid-HOLD: imem_req and instr_valid drop asynchronously. The pending fetch is abandoned; the memory must tolerate a withdrawn request.
- No X on any output after reset.

Optional Feature:
Macro INSTR_FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs retired_cnt (32) and stall_cnt (32), both 0 at reset.
  - retired_cnt increments on every instr_valid & instr_ready handshake.
  - stall_cnt increments on every cycle that is (FETCH & !imem_ready) or (HOLD & !instr_ready).
  - Both counters wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding IDLE/FETCH/HOLD as a 2-bit enum;
  - OPCODE_MSB=31, OPCODE_LSB=26, FUNCT_MSB=5, FUNCT_LSB=0;
  - the PC increment constant 4.
- One combinational sub-module, pc_next_calc (pc, npc_sel, branch_imm -> next_pc), reused later by the jump logic.
- FSM, PC register and output registers stay in instr_fetch.

Test Plan:
- Reset release, imem_ready=1 every cycle, instr_ready=1: imem_addr sequence 0x0, 0x4, 0x8. instr_valid first high in cycle 3. instr_pc matches each address.
- imem_rdata=32'h0000_0020 (add): op_code=6'h00, funct=6'h20, instr=32'h0000_0020, held stable while instr_ready=0 for 5 cycles.
- At pc=0x100, handshake with npc_sel=1, branch_imm=16'hFFFE: next imem_addr=0xFC. With branch_imm=16'h0003: next imem_addr=0x110.
- RESET_PC=32'hFFFF_FFFC, npc_sel=0: second fetch address is 32'h0000_0000.
- imem_ready low for 4 cycles: imem_req and imem_addr stable. Pulse rst_n low mid-wait: imem_req=0 immediately and the next fetch restarts at RESET_PC.
- With INSTR_FETCH_PERF_CNT_EN, 3 instructions each with a 2-cycle memory stall: retired_cnt=3, stall_cnt=6.
